// File: rtl/cog_segment_accumulator.sv
// Accumulates per-segment moments (count, sum I, sum x*I) from the CoG receiver
// stream and emits one registered result per segment of at least MIN_FIG_LEN pixels.
module cog_segment_accumulator #(
    parameter int DATA_WIDTH  = 8,
    parameter int MIN_FIG_LEN = 3
) (
    input  logic                     i_sys_clk,
    input  logic                     i_sys_areset,
    input  logic [DATA_WIDTH-1:0]    i_data_image,
    input  logic                     i_data_valid,
    input  logic [10:0]              i_start_point,
    input  logic                     i_start_of_fig,
    input  logic                     i_end_of_fig,
    input  logic                     i_end_of_line,
    input  logic                     i_end_of_frame,
    input  logic                     i_new_frame,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [10:0]              o_count,
    output logic [DATA_WIDTH+10:0]   o_sum_i,
    output logic [DATA_WIDTH+21:0]   o_sum_xi,
    output logic [10:0]              o_start_x,
    output logic [10:0]              o_line,
    output logic                     o_frame_done,
    output logic                     o_overflow,
    output logic                     o_protocol_err
);

    localparam int SI_W  = DATA_WIDTH + 11;
    localparam int SXI_W = DATA_WIDTH + 22;

    typedef enum logic [1:0] {IDLE, IN_FRAME, ACCUM} state_t;

    state_t            state;
    logic [10:0]       acc_count;
    logic [SI_W-1:0]   acc_i;
    logic [SXI_W-1:0]  acc_xi;
    logic [10:0]       acc_x;
    logic [10:0]       start_x;
    logic [10:0]       line_cnt;

    logic [10:0]       base_count, nxt_count, x_cur, nxt_start;
    logic [SI_W-1:0]   base_i, nxt_i;
    logic [SXI_W-1:0]  base_xi, nxt_xi;
    logic              seg_pixel, finalize, keep, load, drop, res_fire;

    // A start marker (legal or not) rebases the accumulators on the new start,
    // so the restart and 1-pixel cases share the same datapath as a normal pixel.
    always_comb begin
        base_count = i_start_of_fig ? '0 : acc_count;
        base_i     = i_start_of_fig ? '0 : acc_i;
        base_xi    = i_start_of_fig ? '0 : acc_xi;
        x_cur      = i_start_of_fig ? i_start_point : acc_x;
        nxt_start  = i_start_of_fig ? i_start_point : start_x;
        nxt_count  = base_count + 11'd1;
        nxt_i      = base_i + SI_W'(i_data_image);
        nxt_xi     = base_xi + SXI_W'(x_cur) * SXI_W'(i_data_image);
        seg_pixel  = ((state == ACCUM) && i_data_valid) ||
                     ((state == IN_FRAME) && i_start_of_fig);
        finalize   = seg_pixel && i_end_of_fig;
        keep       = finalize && (nxt_count >= 11'(MIN_FIG_LEN));
        res_fire   = o_res_valid && i_res_ready;
        load       = keep && (!o_res_valid || i_res_ready);
        drop       = keep && !load;
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
        if (i_sys_areset) begin
            state          <= IDLE;
            acc_count      <= '0;
            acc_i          <= '0;
            acc_xi         <= '0;
            acc_x          <= '0;
            start_x        <= '0;
            line_cnt       <= '0;
            o_res_valid    <= 1'b0;
            o_count        <= '0;
            o_sum_i        <= '0;
            o_sum_xi       <= '0;
            o_start_x      <= '0;
            o_line         <= '0;
            o_frame_done   <= 1'b0;
            o_overflow     <= 1'b0;
            o_protocol_err <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (res_fire) begin
                o_res_valid <= 1'b0;
            end
            if (i_new_frame) begin
                state          <= IN_FRAME;
                line_cnt       <= '0;
                o_overflow     <= 1'b0;
                o_protocol_err <= 1'b0;
            end else if (state != IDLE) begin
                if (seg_pixel) begin
                    acc_count <= nxt_count;
                    acc_i     <= nxt_i;
                    acc_xi    <= nxt_xi;
                    acc_x     <= x_cur + 11'd1;
                    start_x   <= nxt_start;
                end
                if ((state == ACCUM) && i_start_of_fig) begin
                    o_protocol_err <= 1'b1;
                end
                if ((state == IN_FRAME) && i_end_of_fig && !i_start_of_fig) begin
                    o_protocol_err <= 1'b1;
                end
                if (load) begin
                    o_res_valid <= 1'b1;
                    o_count     <= nxt_count;
                    o_sum_i     <= nxt_i;
                    o_sum_xi    <= nxt_xi;
                    o_start_x   <= nxt_start;
                    o_line      <= line_cnt;
                end
                if (drop) begin
                    o_overflow <= 1'b1;
                end
                if (i_end_of_line) begin
                    line_cnt <= line_cnt + 11'd1;
                end
                // End of frame wins the state update after any same-cycle finalize.
                if (i_end_of_frame) begin
                    state        <= IDLE;
                    o_frame_done <= 1'b1;
                end else if (finalize) begin
                    state <= IN_FRAME;
                end else if (seg_pixel) begin
                    state <= ACCUM;
                end
            end
        end
    end

endmodule

// File: tb/tb_cog_segment_accumulator.sv
// Directed bench for cog_segment_accumulator: a pixel-list model of each segment
// is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_cog_segment_accumulator;

    localparam int DW   = 8;
    localparam int MINL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] img;
    logic          valid, sof, eof, eol, eofr, nf, ready;
    logic [10:0]   sp;
    logic          res_valid, frame_done, overflow, perr;
    logic [10:0]   count, start_x, line;
    logic [DW+10:0] sum_i;
    logic [DW+21:0] sum_xi;

    always #5 clk = ~clk;

    cog_segment_accumulator #(.DATA_WIDTH(DW), .MIN_FIG_LEN(MINL)) dut (
        .i_sys_clk      (clk),
        .i_sys_areset   (rst),
        .i_data_image   (img),
        .i_data_valid   (valid),
        .i_start_point  (sp),
        .i_start_of_fig (sof),
        .i_end_of_fig   (eof),
        .i_end_of_line  (eol),
        .i_end_of_frame (eofr),
        .i_new_frame    (nf),
        .o_res_valid    (res_valid),
        .i_res_ready    (ready),
        .o_count        (count),
        .o_sum_i        (sum_i),
        .o_sum_xi       (sum_xi),
        .o_start_x      (start_x),
        .o_line         (line),
        .o_frame_done   (frame_done),
        .o_overflow     (overflow),
        .o_protocol_err (perr)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a frame/segment flag pair and the list of pixels of the open segment.
    bit     m_in_frame, m_in_seg;
    int     pix[$];
    int     m_start, m_line;
    bit     e_valid, e_fd, e_ovf, e_perr;
    longint e_count, e_si, e_sxi, e_start, e_line;

    function automatic void model_reset();
        m_in_frame = 0; m_in_seg = 0; pix.delete(); m_start = 0; m_line = 0;
        e_valid = 0; e_fd = 0; e_ovf = 0; e_perr = 0;
        e_count = 0; e_si = 0; e_sxi = 0; e_start = 0; e_line = 0;
    endfunction

    function automatic void model_step();
        bit fire, fin, loaded;
        fire   = e_valid && ready;
        fin    = 0;
        loaded = 0;
        e_fd   = 0;
        if (nf) begin
            m_in_frame = 1; m_in_seg = 0; pix.delete();
            m_line = 0; e_ovf = 0; e_perr = 0;
        end else if (m_in_frame) begin
            if (valid) begin
                if (sof) begin
                    if (m_in_seg) e_perr = 1;
                    pix.delete();
                    m_start  = int'(sp);
                    m_in_seg = 1;
                    pix.push_back(int'(img));
                end else if (m_in_seg) begin
                    pix.push_back(int'(img));
                end else if (eof) begin
                    e_perr = 1;
                end
                if (eof && m_in_seg) begin
                    fin = 1;
                    m_in_seg = 0;
                end
            end
            if (fin && pix.size() >= MINL) begin
                if (!e_valid || fire) begin
                    loaded  = 1;
                    e_count = pix.size();
                    e_si    = 0;
                    e_sxi   = 0;
                    foreach (pix[k]) begin
                        e_si  += pix[k];
                        e_sxi += longint'(m_start + k) * pix[k];
                    end
                    e_start = m_start;
                    e_line  = m_line;
                end else begin
                    e_ovf = 1;
                end
            end
            if (eol) m_line = (m_line + 1) % 2048;
            if (eofr) begin
                m_in_frame = 0; m_in_seg = 0; e_fd = 1;
            end
        end
        if (loaded) e_valid = 1;
        else if (fire) e_valid = 0;
    endfunction

    task automatic compare_all();
        chk("res_valid", res_valid, e_valid);
        chk("frame_done", frame_done, e_fd);
        chk("overflow", overflow, e_ovf);
        chk("protocol_err", perr, e_perr);
        if (e_valid) begin
            chk("count", count, e_count);
            chk("sum_i", sum_i, e_si);
            chk("sum_xi", sum_xi, e_sxi);
            chk("start_x", start_x, e_start);
            chk("line", line, e_line);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        valid = 0; sof = 0; eof = 0; eol = 0; eofr = 0; nf = 0; img = '0; sp = '0;
    endtask

    task automatic px(input int i, input bit s, input bit e, input int spv);
        valid = 1; img = DW'(i); sof = s; eof = e; sp = 11'(spv);
        tick();
    endtask

    task automatic seg3(input int spv, input int a, input int b, input int c);
        px(a, 1, 0, spv);
        px(b, 0, 0, 0);
        px(c, 0, 1, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic new_frame();
        nf = 1;
        tick();
    endtask

    initial begin
        rst = 1; valid = 0; sof = 0; eof = 0; eol = 0; eofr = 0; nf = 0;
        img = '0; sp = '0; ready = 1;
        model_reset();
        #2;
        chk("reset_valid", res_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_sum_xi", sum_xi, 0);
        chk("reset_flags", {frame_done, overflow, perr}, 0);
        @(negedge clk);
        rst = 0;
        idle(2);

        // Single segment
        new_frame();
        seg3(100, 10, 20, 30);
        chk("t1_valid", res_valid, 1);
        chk("t1_count", count, 3);
        chk("t1_sum_i", sum_i, 60);
        chk("t1_sum_xi", sum_xi, 6080);
        chk("t1_start_x", start_x, 100);
        chk("t1_line", line, 0);
        idle(1);

        // Short segment is dropped silently
        px(7, 1, 0, 10);
        px(8, 0, 1, 0);
        idle(2);
        chk("t2_valid", res_valid, 0);
        chk("t2_flags", {overflow, perr}, 0);

        // Line index with end_of_line coinciding with end_of_fig
        eol = 1; tick();
        eol = 1; tick();
        px(1, 1, 0, 5);
        px(2, 0, 0, 0);
        eol = 1;
        px(3, 0, 1, 0);
        chk("t3_line", line, 2);
        idle(1);
        seg3(50, 4, 5, 6);
        chk("t3_next_line", line, 3);

        // Back-to-back segments at full throughput
        seg3(300, 1, 1, 1);
        seg3(303, 2, 2, 2);
        chk("tp_count", count, 3);
        chk("tp_sum_xi", sum_xi, 1824);
        idle(1);

        // Backpressure: first result held, second dropped
        ready = 0;
        seg3(400, 9, 9, 9);
        idle(2);
        seg3(500, 1, 2, 3);
        chk("t4_overflow", overflow, 1);
        chk("t4_held_start", start_x, 400);
        chk("t4_held_sum_i", sum_i, 27);
        ready = 1;
        idle(1);
        new_frame();
        chk("t4_ovf_cleared", overflow, 0);

        // Protocol errors
        px(10, 1, 0, 600);
        px(11, 0, 0, 0);
        px(1, 1, 0, 700);
        px(2, 0, 0, 0);
        px(3, 0, 1, 0);
        chk("t5_perr", perr, 1);
        chk("t5_count", count, 3);
        chk("t5_start_x", start_x, 700);
        chk("t5_sum_xi", sum_xi, 4208);
        idle(1);
        new_frame();
        chk("t5_perr_cleared", perr, 0);
        px(5, 0, 1, 0);
        chk("t5_stray_eof_perr", perr, 1);
        chk("t5_stray_eof_valid", res_valid, 0);

        // End of frame coinciding with end_of_fig
        new_frame();
        px(1, 1, 0, 10);
        px(2, 0, 0, 0);
        eofr = 1;
        px(3, 0, 1, 0);
        chk("t6_valid", res_valid, 1);
        chk("t6_frame_done", frame_done, 1);
        chk("t6_sum_xi", sum_xi, 10 + 22 + 36);
        tick();
        chk("t6_frame_done_pulse", frame_done, 0);
        seg3(20, 5, 5, 5);
        idle(1);
        chk("t6_idle_ignored", res_valid, 0);

        // Asynchronous reset mid-segment with a pending result
        new_frame();
        ready = 0;
        seg3(30, 7, 7, 7);
        px(1, 1, 0, 40);
        px(2, 0, 0, 0);
        #2;
        rst = 1;
        #1;
        chk("rst_mid_valid", res_valid, 0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_sum_i", sum_i, 0);
        chk("rst_mid_sum_xi", sum_xi, 0);
        chk("rst_mid_start_line", {start_x, line}, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        ready = 1;
        idle(2);

        // Recovery after reset, full-scale pixels at column 0
        new_frame();
        seg3(0, 255, 255, 255);
        chk("rec_sum_i", sum_i, 765);
        chk("rec_sum_xi", sum_xi, 765);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
